cla_mp_sequencer: RTL



---
 rtl/cla_mp_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cla_mp_sequencer.sv
//==============================================================================
// Module      : cla_mp_sequencer (with helper cla_adder)
// Description : Multi-precision add/subtract; one 16-bit CLA slice walked
//               LSW-first over WORDS words with a registered carry chain.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cla_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Four 4-bit lookahead groups; bit carries expanded from the group carry-in
    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            localparam int B = 4 * k;
            assign w_gg[k] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                           | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                           | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
            assign w_gp[k] = &w_p[B+3:B];
            assign w_c[B]   = w_gc[k];
            assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
            assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_gc[k]);
            assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
        end
    endgenerate

    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

    assign s    = w_p ^ w_c;
    assign cout = w_gc[4];
endmodule

module cla_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic              cout,
    output logic              overflow
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [15:0] w_a_word;
    logic [15:0] w_b_word;
    logic [15:0] w_s;
    logic        w_cout;
    logic        w_ovf;

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_word = r_a[16*i +: 16];
                w_b_word = r_b[16*i +: 16];
            end
        end
    end

    cla_adder u_add (
        .a    (w_a_word),
        .b    (w_b_word),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // r_b already holds the effective (possibly inverted) operand
    assign w_ovf = (r_a[W-1] == r_b[W-1]) && (w_s[15] != r_a[W-1]);

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[16*i +: 16] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_cout;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
